// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: bypass select codes,
// FSM state enum, pipeline slot record and the slot match helper.
// Optional build macro: HAZ_ZERO_REG_EN (register 0 hardwired to zero).
package hazard_pkg;

  // Slot address field is sized for the widest supported register file;
  // narrower addresses are zero-extended, which keeps comparisons exact.
  localparam int unsigned SLOT_AW = 8;

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_EX = 2'd1;
  localparam logic [1:0] SEL_DM = 2'd2;
  localparam logic [1:0] SEL_WB = 2'd3;

  typedef enum logic [1:0] {
    StRun,
    StLoadStall,
    StFlush
  } state_e;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic               is_load;
    logic [SLOT_AW-1:0] rw;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // True when an in-flight slot produces the register a decode operand reads.
  function automatic logic slot_hit(input slot_t s, input logic [SLOT_AW-1:0] addr,
                                    input logic rd_en);
    logic w_rw_ok;
`ifdef HAZ_ZERO_REG_EN
    w_rw_ok = (s.rw != '0);
`else
    w_rw_ok = 1'b1;
`endif
    return rd_en & s.valid & s.we & (s.rw == addr) & w_rw_ok;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Decode-side bundle between the decode block and the hazard/forwarding unit.
// master = decode block, slave = hazard_fwd_unit.
interface hazard_fwd_unit_if #(
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] ra;
  logic [REG_AW-1:0] rb;
  logic [REG_AW-1:0] rw;
  logic              use_a;
  logic              use_b;
  logic              we;
  logic              is_load;
  logic              flush;
  logic [1:0]        mux_sel_A;
  logic [1:0]        mux_sel_B;
  logic              stall;
  logic              stall_pm;
  logic              bubble;

  modport master (
    output ra, rb, rw, use_a, use_b, we, is_load, flush,
    input  mux_sel_A, mux_sel_B, stall, stall_pm, bubble
  );

  modport slave (
    input  ra, rb, rw, use_a, use_b, we, is_load, flush,
    output mux_sel_A, mux_sel_B, stall, stall_pm, bubble
  );
endinterface

// File: rtl/hazard_fwd_cmp.sv
// Per-operand priority comparator: picks the youngest in-flight producer of
// the operand, reports a load-use hazard, and masks forwarding from a load
// whose data is not yet available.
module hazard_fwd_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned FWD_DEPTH = 3,
  parameter int unsigned LOAD_LAT  = 1
) (
  input  logic [SLOT_AW-1:0] i_addr,
  input  logic               i_use,
  input  slot_t              i_slot_ex,
  input  slot_t              i_slot_dm,
  input  slot_t              i_slot_wb,
  output logic [1:0]         o_sel,
  output logic               o_load_haz
);

  logic       w_hit_ex;
  logic       w_hit_dm;
  logic       w_hit_wb;
  logic [1:0] w_sel;
  logic       w_haz;

  assign w_hit_ex = slot_hit(i_slot_ex, i_addr, i_use);
  assign w_hit_dm = slot_hit(i_slot_dm, i_addr, i_use);
  assign w_hit_wb = slot_hit(i_slot_wb, i_addr, i_use);

  // Youngest match decides both the hazard and the bypass source; stages
  // beyond FWD_DEPTH fall back to the register file.
  always_comb begin
    w_sel = SEL_RF;
    w_haz = 1'b0;
    if (w_hit_ex) begin
      w_haz = i_slot_ex.is_load && (LOAD_LAT >= 32'd1);
      if (FWD_DEPTH >= 32'd1) w_sel = SEL_EX;
    end else if (w_hit_dm) begin
      w_haz = i_slot_dm.is_load && (LOAD_LAT >= 32'd2);
      if (FWD_DEPTH >= 32'd2) w_sel = SEL_DM;
    end else if (w_hit_wb) begin
      w_haz = i_slot_wb.is_load && (LOAD_LAT >= 32'd3);
      if (FWD_DEPTH >= 32'd3) w_sel = SEL_WB;
    end
  end

  // Load data not ready yet: never bypass from that slot.
  assign o_sel      = w_haz ? SEL_RF : w_sel;
  assign o_load_haz = w_haz;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 16-bit pipelined MIPS core.
// Tracks destinations through EX/DM/WB, drives operand bypass selects,
// load-use stalls and post-jump flush bubbles.
// Optional build macro: HAZ_ZERO_REG_EN (register 0 never forwards/stalls).
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FWD_DEPTH = 3,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned FLUSH_CYC = 2
) (
  input logic               clk,
  input logic               reset,
  hazard_fwd_unit_if.slave  bus
);

  slot_t      r_ex;
  slot_t      r_dm;
  slot_t      r_wb;
  state_e     r_state;
  logic [2:0] r_cnt;

  slot_t      w_entry;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_haz_a;
  logic       w_haz_b;
  logic       w_flushing;
  logic       w_load_haz;
  logic       w_issue;

  assign w_entry = '{valid:   1'b1,
                     we:      bus.we,
                     is_load: bus.is_load,
                     rw:      SLOT_AW'(bus.rw)};

  hazard_fwd_cmp #(
    .FWD_DEPTH (FWD_DEPTH),
    .LOAD_LAT  (LOAD_LAT)
  ) u_cmp_a (
    .i_addr     (SLOT_AW'(bus.ra)),
    .i_use      (bus.use_a),
    .i_slot_ex  (r_ex),
    .i_slot_dm  (r_dm),
    .i_slot_wb  (r_wb),
    .o_sel      (w_sel_a),
    .o_load_haz (w_haz_a)
  );

  hazard_fwd_cmp #(
    .FWD_DEPTH (FWD_DEPTH),
    .LOAD_LAT  (LOAD_LAT)
  ) u_cmp_b (
    .i_addr     (SLOT_AW'(bus.rb)),
    .i_use      (bus.use_b),
    .i_slot_ex  (r_ex),
    .i_slot_dm  (r_dm),
    .i_slot_wb  (r_wb),
    .o_sel      (w_sel_b),
    .o_load_haz (w_haz_b)
  );

  // Stall/bubble decode; a flush in the same cycle suppresses the load stall
  // and lets the jump itself issue.
  always_comb begin
    w_flushing    = (r_state == StFlush);
    w_load_haz    = (w_haz_a | w_haz_b) & ~bus.flush & ~w_flushing;
    w_issue       = ~w_flushing & ~w_load_haz;
    bus.stall     = w_flushing | w_load_haz;
    bus.stall_pm  = w_load_haz;
    bus.bubble    = ~w_issue;
    bus.mux_sel_A = w_sel_a;
    bus.mux_sel_B = w_sel_b;
  end

  // Pipeline slot shift: decode entry or bubble into EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex <= SLOT_EMPTY;
      r_dm <= SLOT_EMPTY;
      r_wb <= SLOT_EMPTY;
    end else begin
      r_wb <= r_dm;
      r_dm <= r_ex;
      r_ex <= w_issue ? w_entry : SLOT_EMPTY;
    end
  end

  // Control FSM: flush has priority; flush counter saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StRun;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        StRun, StLoadStall: begin
          if (bus.flush) begin
            r_state <= StFlush;
            r_cnt   <= 3'(FLUSH_CYC - 1);
          end else if (w_haz_a | w_haz_b) begin
            r_state <= StLoadStall;
          end else begin
            r_state <= StRun;
          end
        end
        StFlush: begin
          if (bus.flush) begin
            r_cnt <= 3'(FLUSH_CYC - 1);
          end else if (r_cnt == 3'd0) begin
            r_state <= StRun;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= StRun;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule
